// File: rtl/newton_step_pkg.sv
// Shared types and constants for the reciprocal-square-root Newton refinement step.
package newton_step_pkg;

    localparam int unsigned SIGN_W  = 1;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned FP_W    = SIGN_W + EXP_W + FRAC_W;
    localparam int unsigned MANT_W  = FRAC_W + 1;
    localparam int unsigned EXT_W   = EXP_W + 2;
    localparam int unsigned LZ_W    = 5;

    // Signed exponent arithmetic helpers (room for sums up to 2*255 and negatives).
    localparam logic signed [EXT_W-1:0] E_BIAS = EXT_W'(127);
    localparam logic signed [EXT_W-1:0] E_MAX  = EXT_W'(255);
    localparam logic signed [EXT_W-1:0] E_ZERO = EXT_W'(0);

    localparam logic [FP_W-1:0] ONE_HALF_3  = 32'h3FC00000;
    localparam logic [FP_W-1:0] RES_POS_INF = 32'h7F800000;
    localparam logic [FP_W-1:0] RES_ZERO    = 32'h00000000;
    localparam logic [FP_W-1:0] RES_QNAN    = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        MH,
        SUB,
        MY,
        DONE
    } state_t;

endpackage

// File: rtl/fp32_mul.sv
// Truncating single-precision multiplier; zero/denormal inputs act as zero.
module fp32_mul
    import newton_step_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p
);

    logic                    sign;
    logic [EXP_W-1:0]        ea;
    logic [EXP_W-1:0]        eb;
    logic [2*MANT_W-1:0]     prod;
    logic [MANT_W:0]         prod_hi;
    logic [MANT_W-2:0]       unused_prod_lo;
    logic [FRAC_W-1:0]       frac;
    logic signed [EXT_W-1:0] e;

    assign prod = {1'b1, a[FRAC_W-1:0]} * {1'b1, b[FRAC_W-1:0]};
    assign {prod_hi, unused_prod_lo} = prod;

    // Sign/exponent combine, single-step normalisation, underflow/overflow clamp.
    always_comb begin
        sign = a[FP_W-1] ^ b[FP_W-1];
        ea   = a[FP_W-2 -: EXP_W];
        eb   = b[FP_W-2 -: EXP_W];
        frac = prod_hi[MANT_W] ? prod_hi[MANT_W-1:1] : prod_hi[MANT_W-2:0];
        e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS
             + $signed({{(EXT_W-1){1'b0}}, prod_hi[MANT_W]});
        if (ea == '0 || eb == '0 || e <= E_ZERO) begin
            p = {sign, (FP_W-1)'(0)};
        end else if (e >= E_MAX) begin
            p = {sign, {EXP_W{1'b1}}, FRAC_W'(0)};
        end else begin
            p = {sign, e[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/newton_step.sv
// Iterative Newton-Raphson refinement of a 1/sqrt(x) estimate with one shared multiplier.
module newton_step
    import newton_step_pkg::*;
#(
    parameter int unsigned ITER = 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] y_in,
    input  logic [FP_W-1:0] half_x,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] y_out,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int unsigned CNT_W = 2;

    state_t            state_q;
    state_t            state_d;
    logic [FP_W-1:0]   y_q;
    logic [FP_W-1:0]   hx_q;
    logic [FP_W-1:0]   t_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              spec_q;
    logic [FP_W-1:0]   spec_val_q;
    logic              spec_d;
    logic [FP_W-1:0]   spec_val_d;
    logic              last_iter;
    logic [FP_W-1:0]   mul_a;
    logic [FP_W-1:0]   mul_b;
    logic [FP_W-1:0]   mul_p;
    logic [FP_W-1:0]   sub_r;

    assign last_iter = (cnt_q >= CNT_W'(ITER - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = SQ;
            SQ:      state_d = MH;
            MH:      state_d = SUB;
            SUB:     state_d = MY;
            MY:      state_d = last_iter ? DONE : SQ;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand classes whose answer is fixed regardless of the estimate.
    always_comb begin
        spec_d     = 1'b1;
        spec_val_d = RES_ZERO;
        if (half_x[FP_W-2 -: EXP_W] == '0)          spec_val_d = RES_POS_INF;
        else if (half_x[FP_W-2 -: EXP_W] == '1)     spec_val_d = RES_ZERO;
        else if (half_x[FP_W-1])                    spec_val_d = RES_QNAN;
        else                                        spec_d     = 1'b0;
    end

    // Multiplier operand select for the time-shared product.
    always_comb begin
        mul_a = y_q;
        mul_b = t_q;
        unique case (state_q)
            SQ:      begin mul_a = y_q;  mul_b = y_q; end
            MH:      begin mul_a = hx_q; mul_b = t_q; end
            default: begin mul_a = y_q;  mul_b = t_q; end
        endcase
    end

    fp32_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    logic [FP_W-1:0]         op_b;
    logic [FP_W-2:0]         key_a;
    logic [FP_W-2:0]         key_b;
    logic [FP_W-1:0]         big;
    logic [FP_W-1:0]         sml;
    logic [EXP_W-1:0]        e_big;
    logic [EXP_W-1:0]        e_sml;
    logic [EXP_W-1:0]        e_diff;
    logic [MANT_W-1:0]       m_big;
    logic [MANT_W-1:0]       m_sh;
    logic [MANT_W:0]         sum;
    logic [LZ_W-1:0]         lz;
    logic [FRAC_W-1:0]       norm_frac;
    logic                    unused_norm_msb;
    logic signed [EXT_W-1:0] e_res;

    // 1.5 - t: magnitude-ordered align, add/subtract, leading-zero normalise, truncate.
    always_comb begin
        op_b   = {~t_q[FP_W-1], t_q[FP_W-2:0]};
        key_a  = ONE_HALF_3[FP_W-2:0];
        key_b  = (op_b[FP_W-2 -: EXP_W] == '0) ? '0 : op_b[FP_W-2:0];
        big    = (key_a >= key_b) ? ONE_HALF_3 : op_b;
        sml    = (key_a >= key_b) ? op_b : ONE_HALF_3;
        e_big  = big[FP_W-2 -: EXP_W];
        e_sml  = sml[FP_W-2 -: EXP_W];
        e_diff = e_big - e_sml;
        m_big  = (e_big == '0) ? '0 : {1'b1, big[FRAC_W-1:0]};
        m_sh   = (e_sml == '0 || e_diff >= EXP_W'(25)) ? '0 : ({1'b1, sml[FRAC_W-1:0]} >> e_diff);
        sum    = (big[FP_W-1] == sml[FP_W-1]) ? ({1'b0, m_big} + {1'b0, m_sh})
                                              : ({1'b0, m_big} - {1'b0, m_sh});
        lz = '0;
        for (int i = 0; i < int'(MANT_W); i++) begin
            if (sum[i]) lz = LZ_W'(int'(MANT_W) - 1 - i);
        end
        {unused_norm_msb, norm_frac} = sum[MANT_W-1:0] << lz;
        e_res = $signed({2'b00, e_big}) - $signed({{(EXT_W-LZ_W){1'b0}}, lz});
        if (sum == '0) begin
            sub_r = RES_ZERO;
        end else if (sum[MANT_W]) begin
            if (e_big >= EXP_W'(254)) sub_r = {big[FP_W-1], {EXP_W{1'b1}}, FRAC_W'(0)};
            else                      sub_r = {big[FP_W-1], e_big + EXP_W'(1), sum[MANT_W-1:1]};
        end else if (e_res <= E_ZERO) begin
            sub_r = {big[FP_W-1], (FP_W-1)'(0)};
        end else begin
            sub_r = {big[FP_W-1], e_res[EXP_W-1:0], norm_frac};
        end
    end

    // Datapath registers and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            y_q        <= '0;
            hx_q       <= '0;
            t_q        <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            y_out      <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            case (state_q)
                IDLE: if (in_valid) begin
                    y_q        <= y_in;
                    hx_q       <= half_x;
                    cnt_q      <= '0;
                    spec_q     <= spec_d;
                    spec_val_q <= spec_val_d;
                end
                SQ, MH: t_q <= mul_p;
                SUB:    t_q <= sub_r;
                MY: begin
                    y_q <= mul_p;
                    if (!last_iter) cnt_q <= cnt_q + CNT_W'(1);
                    else            y_out <= spec_q ? spec_val_q : mul_p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_newton_step.sv
// Self-checking bench for newton_step: vector table, handshake/reset sequences, random stream.
module tb_newton_step;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] y_in, half_x, y_out;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] y_in2, half_x2, y_out2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    newton_step #(.ITER(1)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .half_x(half_x), .in_valid(in_valid),
        .in_ready(in_ready), .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    newton_step #(.ITER(2)) dut2 (
        .clk(clk), .rst(rst), .y_in(y_in2), .half_x(half_x2), .in_valid(in_valid2),
        .in_ready(in_ready2), .y_out(y_out2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    typedef struct {
        logic [31:0] hx;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] q[$];

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    // IEEE single bits to real (exponent 0 read as zero).
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    // Issue one operand on the ITER=1 instance (out_ready assumed high) and measure latency.
    task automatic run_op(input logic [31:0] hx, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        half_x = hx; y_in = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        res = y_out;
    endtask

    initial begin
        logic [31:0] res, first;
        int          lat;
        bit          seen;
        int          got;
        real         err;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; y_in = '0; half_x = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; y_in2 = '0; half_x2 = '0;

        vecs[0]  = '{32'h40000000, 32'h3EF759DF, 32'h3EFF8000, 32'h3EFFA000};
        vecs[1]  = '{32'h00000000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
        vecs[2]  = '{32'h7F800000, 32'h3F800000, 32'h00000000, 32'h00000000};
        vecs[3]  = '{32'hBF000000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000};
        vecs[4]  = '{32'h00012345, 32'h3F800000, 32'h7F800000, 32'h7F800000};
        vecs[5]  = '{32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        vecs[6]  = '{32'h40000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
        vecs[7]  = '{32'h3E800000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        vecs[8]  = '{32'h3F000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[9]  = '{32'h3F000000, 32'h7F000000, 32'hFF800000, 32'hFF800000};
        vecs[10] = '{32'h3F000000, 32'h1F800000, 32'h1FC00000, 32'h1FC00000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check(out_valid === 1'b0, "reset_out_valid", {31'b0, out_valid}, 32'h0);
        check(y_out === 32'h0, "reset_y_out", y_out, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check(in_ready === 1'b1, "reset_in_ready", {31'b0, in_ready}, 32'h1);
        check(in_ready2 === 1'b1, "reset_in_ready_iter2", {31'b0, in_ready2}, 32'h1);

        // Vector table at nominal latency.
        foreach (vecs[i]) begin
            run_op(vecs[i].hx, vecs[i].y, res, lat);
            check(lat == 4, $sformatf("latency[%0d]", i), 32'(lat), 32'd4);
            check(res >= vecs[i].lo && res <= vecs[i].hi, $sformatf("value[%0d]", i), res, vecs[i].lo);
        end

        // Two iterations converge to 1.0 for x=1.
        @(posedge clk); #1;
        half_x2 = 32'h3F000000; y_in2 = 32'h3F7759DF; in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 64) begin @(posedge clk); #1; lat++; end
        check(lat == 8, "iter2_latency", 32'(lat), 32'd8);
        err = f2r(y_out2) - 1.0;
        if (err < 0.0) err = -err;
        check(err < 1.0e-5, "iter2_value", y_out2, 32'h3F800000);

        // DONE stall with in_valid held high.
        @(posedge clk); #1;
        out_ready = 1'b0;
        half_x = 32'h40000000; y_in = 32'h3EF759DF; in_valid = 1'b1;
        @(posedge clk); #1;
        half_x = 32'h00000000; y_in = 32'h3F800000;
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        check(lat == 4, "stall_latency", 32'(lat), 32'd4);
        first = y_out;
        check(first >= 32'h3EFF8000 && first <= 32'h3EFFA000, "stall_value", first, 32'h3EFF8000);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check(out_valid === 1'b1 && in_ready === 1'b0 && y_out === first,
                  $sformatf("stall_hold[%0d]", c), y_out, first);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check(out_valid === 1'b0 && in_ready === 1'b1, "handshake_no_accept",
              {30'b0, out_valid, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        check(lat == 4, "second_latency", 32'(lat), 32'd4);
        check(y_out === 32'h7F800000, "second_value", y_out, 32'h7F800000);

        // Reset during SUB aborts the operand.
        @(posedge clk); #1;
        half_x = 32'h3F000000; y_in = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check(out_valid === 1'b0, "abort_out_valid", {31'b0, out_valid}, 32'h0);
        check(in_ready === 1'b1, "abort_in_ready", {31'b0, in_ready}, 32'h1);
        check(y_out === 32'h0, "abort_y_out", y_out, 32'h0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        check(!seen, "abort_no_result", {31'b0, seen}, 32'h0);

        // Random stream with stalls against 1/sqrt(x).
        got = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [31:0] xb;
                    bit          acc;
                    int          w;
                    xb = {1'b0, 8'($urandom_range(100, 154)), 23'($urandom)};
                    half_x = xb - 32'h00800000;
                    y_in = 32'h5F3759DF - (xb >> 1);
                    in_valid = 1'b1;
                    w = 0;
                    do begin
                        acc = in_ready;
                        @(posedge clk); #1;
                        w++;
                    end while (!acc && w < 1000);
                    q.push_back(xb);
                end
                in_valid = 1'b0;
            end
            begin
                int          cyc;
                bit          ov, ordy;
                logic [31:0] yo, xb;
                real         ref_v, rel;
                cyc = 0;
                while (got < 100 && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    ov = out_valid; ordy = out_ready; yo = y_out;
                    @(posedge clk); #1;
                    cyc++;
                    if (ov && ordy) begin
                        if (q.size() == 0) begin
                            check(1'b0, "stream_extra", yo, 32'h0);
                        end else begin
                            xb = q.pop_front();
                            ref_v = 1.0 / $sqrt(f2r(xb));
                            rel = (f2r(yo) - ref_v) / ref_v;
                            if (rel < 0.0) rel = -rel;
                            check(rel < 0.002, $sformatf("stream[%0d] x=%h", got, xb), yo, xb);
                        end
                        got++;
                    end
                end
            end
        join
        check(got == 100, "stream_count", 32'(got), 32'd100);
        check(q.size() == 0, "stream_leftover", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
